regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the pipelined core; it is the successor to the single-write, dual-read regfile. It adds:
- configurable width, depth, read-port count and write-port count;
- optional write-to-read bypass;
- hardwired-zero register 0;
- a per-register busy scoreboard, so the issue stage can detect pending writes.

It sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, register count; must be a power of 2 and ≥2. Localparam AW = $clog2(NREGS).
- NRD, 2, number of read ports (1..4).
- NWR, 1, number of write ports (1..2).
- BYPASS, 1, 1 = a same-cycle write is forwarded to read data; 0 = reads return array contents only.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- rd_addr_i  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data_o  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]; combinational.
- rd_busy_o  out  NRD  per read port: scoreboard busy bit of rd_addr_i[k]; combinational.
- wr_en_i  in  NWR  per-port write enable.
- wr_addr_i  in  NWR*AW  write addresses.
- wr_data_i  in  NWR*XLEN  write data.
- sb_set_i  in  1  mark register sb_addr_i busy (instruction issued with a destination).
- sb_addr_i  in  AW  scoreboard set address.
- sb_flush_i  in  1  clear all busy bits (pipeline flush).
- busy_vec_o  out  NREGS  registered busy bits, bit i = register i.

Behaviour:
Reset
- rst_i high at a rising edge: all registers ← 0, all busy bits ← 0.
- rst_i has priority over every write, set and flush in the same cycle.
- While rst_i is high, bypass is suppressed, so rd_data_o shows array contents only.

Register 0
- Always reads 0.
- Writes to address 0 are dropped and are never bypassed.
- sb_set_i with sb_addr_i = 0 is ignored; busy bit 0 is constant 0.

Writes
- wr_en_i[j] with wr_addr_i[j] ≠ 0: register updated at the next rising edge; visible in the array one cycle later.
- Two write ports hitting the same address in the same cycle: the higher port index wins.

Reads
- Zero-latency combinational read of the array.
- If BYPASS = 1, rst_i is low, and some enabled write port j has wr_addr_i[j] == rd_addr_i[k] ≠ 0, then rd_data_o[k] = wr_data_i of the highest such j.

Scoreboard update (priority high → low, evaluated at each rising edge)
1. rst_i
2. sb_flush_i: all bits ← 0, and any same-cycle sb_set_i is discarded
3. sb_set_i: bit[sb_addr_i] ← 1
4. enabled write to address a: bit[a] ← 0

- Set and write-clear to the same register in the same cycle: set wins (the newer producer is still in flight).
- Setting a bit that is already busy leaves it busy. No counting: a single producer per register is guaranteed by issue.
- Writes always land in the array, whether or not the target is busy.

rd_busy_o
- rd_busy_o[k] = busy_vec_o[rd_addr_i[k]].
- If BYPASS = 1, it is additionally forced to 0 when a same-cycle enabled write matches rd_addr_i[k], because that data is being forwarded.

Other rules
- Reads never stall or alter state.
- There is no full/empty condition.
- Address arithmetic is unsigned. Addresses ≥ NREGS cannot occur because AW is exact.

Test Plan:
1. Reset, then read all addresses on every port → rd_data_o = 0, busy_vec_o = 0; write 0xDEADBEEF to x0 → read x0 = 0.
2. Write x5 = 0x12345678 (BYPASS=1) while port 0 reads x5 in the same cycle → rd_data_o[0] = 0x12345678 that cycle; with BYPASS=0 → old value (0), and the new value appears the next cycle.
3. NWR=2: port 0 writes x7 = 0xAAAA0000 and port 1 writes x7 = 0x0000BBBB in the same cycle → x7 = 0x0000BBBB afterwards.
4. sb_set_i x9 → busy_vec_o[9] = 1 next cycle and rd_busy_o = 1 for readers of x9; write x9 = 0x42 → busy clears next cycle; set x9 and write x9 in the same cycle → bit stays 1.
5. Set busy on x3, x4, x6, then assert sb_flush_i together with sb_set_i x8 → busy_vec_o = 0 next cycle.
6. Fill x1..x31 with i*0x01010101, assert rst_i for one cycle together with a write to x2 = 0xFFFFFFFF → all registers 0 and all busy bits 0 after the edge.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired-zero x0, optional
// write-to-read bypass and a per-register busy scoreboard for the issue stage.
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 1,
   parameter int BYPASS = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NRD*$clog2(NREGS)-1:0] rd_addr_i,
   output logic [NRD*XLEN-1:0] rd_data_o,
   output logic [NRD-1:0]      rd_busy_o,
   input  logic [NWR-1:0]      wr_en_i,
   input  logic [NWR*$clog2(NREGS)-1:0] wr_addr_i,
   input  logic [NWR*XLEN-1:0] wr_data_i,
   input  logic                sb_set_i,
   input  logic [$clog2(NREGS)-1:0] sb_addr_i,
   input  logic                sb_flush_i,
   output logic [NREGS-1:0]    busy_vec_o
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  mem [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Next scoreboard state: write-clears first, then set overrides, flush overrides all.
   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0))
            busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
      if (sb_flush_i)
         busy_d = '0;
      else if (sb_set_i && (sb_addr_i != '0))
         busy_d[sb_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++)
            mem[i] <= '0;
         busy_q <= '0;
      end else begin
         // Ascending port order lets the highest-indexed port win a collision.
         for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0))
               mem[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
         end
         busy_q <= busy_d;
      end
   end

   always_comb begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rdat;
      logic            rbusy;
      rd_data_o = '0;
      rd_busy_o = '0;
      for (int k = 0; k < NRD; k++) begin
         ra    = rd_addr_i[k*AW +: AW];
         rdat  = (ra == '0) ? '0 : mem[ra];
         rbusy = busy_q[ra];
         if ((BYPASS != 0) && !rst_i && (ra != '0)) begin
            for (int j = 0; j < NWR; j++) begin
               if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == ra)) begin
                  rdat  = wr_data_i[j*XLEN +: XLEN];
                  rbusy = 1'b0;
               end
            end
         end
         rd_data_o[k*XLEN +: XLEN] = rdat;
         rd_busy_o[k]              = rbusy;
      end
   end

   assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two instances (bypass on / off) share
// stimulus; expected outputs are queued by the driver and checked by a monitor.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int NRD = 2;
   localparam int NWR = 2;
   localparam int AW = 5;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic                rst_i;
   logic [NRD*AW-1:0]   rd_addr_i;
   logic [NWR-1:0]      wr_en_i;
   logic [NWR*AW-1:0]   wr_addr_i;
   logic [NWR*XLEN-1:0] wr_data_i;
   logic                sb_set_i;
   logic [AW-1:0]       sb_addr_i;
   logic                sb_flush_i;

   logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
   logic [NRD-1:0]      rd_busy_b, rd_busy_n;
   logic [NREGS-1:0]    busy_vec_b, busy_vec_n;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_b),
      .rd_busy_o(rd_busy_b), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i), .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i),
      .sb_flush_i(sb_flush_i), .busy_vec_o(busy_vec_b));

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
      .clk_i(clk_i), .rst_i(rst_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_n),
      .rd_busy_o(rd_busy_n), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i), .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i),
      .sb_flush_i(sb_flush_i), .busy_vec_o(busy_vec_n));

   typedef struct {
      int                  id;
      logic [NRD*XLEN-1:0] data_b;
      logic [NRD*XLEN-1:0] data_n;
      logic [NRD-1:0]      busy_b;
      logic [NRD-1:0]      busy_n;
      logic [NREGS-1:0]    bvec;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_id = 0;

   // Reference state
   logic [XLEN-1:0] regs [NREGS];
   bit              busy [NREGS];

   // Stimulus fields for the next cycle
   bit              s_rst;
   bit              s_we [NWR];
   logic [AW-1:0]   s_wa [NWR];
   logic [XLEN-1:0] s_wd [NWR];
   bit              s_set;
   logic [AW-1:0]   s_sa;
   bit              s_flush;
   logic [AW-1:0]   s_ra [NRD];

   task automatic idle();
      s_rst = 0; s_set = 0; s_sa = '0; s_flush = 0;
      for (int j = 0; j < NWR; j++) begin s_we[j] = 0; s_wa[j] = '0; s_wd[j] = '0; end
      for (int k = 0; k < NRD; k++) s_ra[k] = '0;
   endtask

   task automatic step();
      exp_t e;
      rst_i      = s_rst;
      sb_set_i   = s_set;
      sb_addr_i  = s_sa;
      sb_flush_i = s_flush;
      for (int j = 0; j < NWR; j++) begin
         wr_en_i[j]                = s_we[j];
         wr_addr_i[j*AW +: AW]     = s_wa[j];
         wr_data_i[j*XLEN +: XLEN] = s_wd[j];
      end
      for (int k = 0; k < NRD; k++) rd_addr_i[k*AW +: AW] = s_ra[k];

      e.id = cyc_id;
      for (int k = 0; k < NRD; k++) begin
         int a;
         bit hit;
         logic [XLEN-1:0] fwd;
         a = int'(s_ra[k]);
         hit = 0;
         fwd = '0;
         for (int j = 0; j < NWR; j++)
            if (s_we[j] && int'(s_wa[j]) == a && a != 0) begin hit = 1; fwd = s_wd[j]; end
         e.data_n[k*XLEN +: XLEN] = (a == 0) ? '0 : regs[a];
         e.busy_n[k]              = busy[a];
         e.data_b[k*XLEN +: XLEN] = (hit && !s_rst) ? fwd : e.data_n[k*XLEN +: XLEN];
         e.busy_b[k]              = (hit && !s_rst) ? 1'b0 : busy[a];
      end
      for (int i = 0; i < NREGS; i++) e.bvec[i] = busy[i];
      exp_q.push_back(e);

      if (s_rst) begin
         for (int i = 0; i < NREGS; i++) begin regs[i] = '0; busy[i] = 0; end
      end else begin
         for (int j = 0; j < NWR; j++)
            if (s_we[j] && s_wa[j] != 0) begin
               regs[s_wa[j]] = s_wd[j];
               busy[s_wa[j]] = 0;
            end
         if (s_flush) begin
            for (int i = 0; i < NREGS; i++) busy[i] = 0;
         end else if (s_set && s_sa != 0) begin
            busy[s_sa] = 1;
         end
      end
      cyc_id++;
      @(posedge clk_i);
      #1;
   endtask

   function automatic void chk(string name, int id, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, id, act, exp);
      end
   endfunction

   // Monitor: outputs are stable mid-cycle, one expectation per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_data_byp",   e.id, 64'(rd_data_b),  64'(e.data_b));
            chk("rd_data_nobyp", e.id, 64'(rd_data_n),  64'(e.data_n));
            chk("rd_busy_byp",   e.id, 64'(rd_busy_b),  64'(e.busy_b));
            chk("rd_busy_nobyp", e.id, 64'(rd_busy_n),  64'(e.busy_n));
            chk("busy_vec_byp",  e.id, 64'(busy_vec_b), 64'(e.bvec));
            chk("busy_vec_nobyp",e.id, 64'(busy_vec_n), 64'(e.bvec));
         end
      end
   end

   initial begin
      for (int i = 0; i < NREGS; i++) begin regs[i] = 'x; busy[i] = 0; end
      idle();
      rst_i = 1; rd_addr_i = '0; wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0;
      sb_set_i = 0; sb_addr_i = '0; sb_flush_i = 0;
      @(posedge clk_i);
      #1;
      // Reset and zero register
      idle(); s_rst = 1; step();
      for (int a = 0; a < NREGS; a++) begin
         idle(); s_ra[0] = AW'(a); s_ra[1] = AW'(NREGS-1-a); step();
      end
      idle(); s_we[0] = 1; s_wa[0] = 0; s_wd[0] = 32'hDEADBEEF; step();
      idle(); step();
      // Bypass
      idle(); s_we[0] = 1; s_wa[0] = 5; s_wd[0] = 32'h12345678; s_ra[0] = 5; step();
      idle(); s_ra[0] = 5; step();
      // Same-address dual write
      idle(); s_we[0] = 1; s_wa[0] = 7; s_wd[0] = 32'hAAAA0000;
      s_we[1] = 1; s_wa[1] = 7; s_wd[1] = 32'h0000BBBB; s_ra[0] = 7; step();
      idle(); s_ra[1] = 7; step();
      // Scoreboard set / clear / set-wins
      idle(); s_set = 1; s_sa = 9; s_ra[0] = 9; step();
      idle(); s_ra[0] = 9; s_ra[1] = 9; step();
      idle(); s_we[1] = 1; s_wa[1] = 9; s_wd[1] = 32'h42; s_ra[0] = 9; step();
      idle(); s_ra[0] = 9; step();
      idle(); s_set = 1; s_sa = 9; s_we[0] = 1; s_wa[0] = 9; s_wd[0] = 32'h43; step();
      idle(); s_ra[1] = 9; step();
      // Flush beats set
      idle(); s_set = 1; s_sa = 3; step();
      idle(); s_set = 1; s_sa = 4; step();
      idle(); s_set = 1; s_sa = 6; s_ra[0] = 3; s_ra[1] = 4; step();
      idle(); s_flush = 1; s_set = 1; s_sa = 8; step();
      idle(); s_ra[0] = 8; s_ra[1] = 6; step();
      // Set on x0 is ignored
      idle(); s_set = 1; s_sa = 0; step();
      idle(); step();
      // Fill then reset with concurrent write
      for (int i = 1; i < NREGS; i++) begin
         idle(); s_we[0] = 1; s_wa[0] = AW'(i); s_wd[0] = 32'(i) * 32'h01010101;
         s_set = 1; s_sa = AW'(NREGS-i); step();
      end
      idle(); s_ra[0] = 31; s_ra[1] = 2; step();
      idle(); s_rst = 1; s_we[0] = 1; s_wa[0] = 2; s_wd[0] = 32'hFFFFFFFF; s_ra[0] = 2; step();
      for (int a = 0; a < NREGS; a++) begin
         idle(); s_ra[0] = AW'(a); s_ra[1] = AW'(a ^ 1); step();
      end
      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         s_rst   = ($urandom_range(0, 99) == 0);
         s_flush = ($urandom_range(0, 31) == 0);
         s_set   = ($urandom_range(0, 3) == 0);
         s_sa    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         for (int j = 0; j < NWR; j++) begin
            s_we[j] = ($urandom_range(0, 1) != 0);
            s_wa[j] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            s_wd[j] = $urandom;
         end
         for (int k = 0; k < NRD; k++)
            s_ra[k] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         step();
      end
      idle();
      rst_i = 0; wr_en_i = '0; sb_set_i = 0; sb_flush_i = 0;
      @(negedge clk_i);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
